kernel_weight_loader: RTL and testbench

//  Read-side sequencer for one weights_rom instance. On a start pulse it walks
//  ROM addresses 0..KERNEL_SIZE-1 and captures each returned word into a local

---
 rtl/kernel_weight_loader.sv | 104 ++++++++++
 tb/tb_kernel_weight_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_weight_loader.sv
// kernel_weight_loader: walks a weights ROM once per start pulse
// and presents the captured kernel as one flat bus.
module kernel_weight_loader #(
   parameter int PARA_WIDTH  = 8,
   parameter int KERNEL_SIZE = 25,
   parameter int ADDR_WIDTH  = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              kernel_valid,
   output logic [KERNEL_SIZE*PARA_WIDTH-1:0] kernel_flat,
   output logic                              rom_r_en,
   output logic [ADDR_WIDTH-1:0]             rom_raddr,
   input  logic [PARA_WIDTH-1:0]             rom_dout
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(KERNEL_SIZE - 1);

   state_t                state;
   state_t                state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] cap_addr;
   logic                  cap_en;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // next-state logic; start outside IDLE is ignored
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (start) state_nxt = FETCH;
         FETCH: if (addr_q == LAST) state_nxt = DRAIN;
         DRAIN: state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // decoded outputs; addr_q is zero whenever not fetching
   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      rom_r_en  = (state == FETCH);
      rom_raddr = addr_q;
   end

   // address counter: one address per FETCH cycle, back to 0 after the last
   always_ff @(posedge clk) begin
      if (rst)
         addr_q <= '0;
      else if (state == FETCH && addr_q != LAST)
         addr_q <= addr_q + 1'b1;
      else
         addr_q <= '0;
   end

   // ROM data lags the request by one cycle, so delay enable and address
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_en   <= 1'b0;
         cap_addr <= '0;
      end else begin
         cap_en   <= rom_r_en;
         cap_addr <= rom_raddr;
      end
   end

   // register bank: write the returned word into the slot it was fetched for
   always_ff @(posedge clk) begin
      if (rst) begin
         kernel_flat <= '0;
      end else begin
         for (int i = 0; i < KERNEL_SIZE; i++) begin
            if (cap_en && cap_addr == ADDR_WIDTH'(i))
               kernel_flat[i*PARA_WIDTH +: PARA_WIDTH] <= rom_dout;
         end
      end
   end

   // kernel_valid drops on an accepted start, rises as DONE is entered
   always_ff @(posedge clk) begin
      if (rst)
         kernel_valid <= 1'b0;
      else if (state == IDLE && start)
         kernel_valid <= 1'b0;
      else if (state == DRAIN)
         kernel_valid <= 1'b1;
   end

endmodule

// File: tb/tb_kernel_weight_loader.sv
// tb_kernel_weight_loader: scoreboard bench; stimulus pushes expected
// ROM requests, done pulses and state snapshots, a monitor pops and compares.
module tb_kernel_weight_loader;

   localparam int PW = 8;
   localparam int KS = 25;
   localparam int AW = 5;
   localparam int FW = KS * PW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic          kernel_valid;
   logic [FW-1:0] kernel_flat;
   logic          rom_r_en;
   logic [AW-1:0] rom_raddr;
   logic [PW-1:0] rom_dout;

   logic          force24 = 1'b0;
   int            cyc = 0;
   int            checks = 0;
   int            passes = 0;

   typedef struct {
      int      cyc;
      int      addr;
   } req_t;

   typedef struct {
      int            cyc;
      logic [FW-1:0] flat;
   } done_t;

   typedef struct {
      int            cyc;
      logic          busy;
      logic          kv;
      logic          ren;
      bit            chk_flat;
      logic [FW-1:0] flat;
   } snap_t;

   req_t  req_q[$];
   done_t done_q[$];
   snap_t snap_q[$];

   kernel_weight_loader #(
      .PARA_WIDTH (PW),
      .KERNEL_SIZE(KS),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .kernel_valid(kernel_valid),
      .kernel_flat (kernel_flat),
      .rom_r_en    (rom_r_en),
      .rom_raddr   (rom_raddr),
      .rom_dout    (rom_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // registered ROM model: word i = 8'h10 + i, optional corruption of word 24
   always @(posedge clk) begin
      if (rom_r_en) begin
         if (force24 && rom_raddr == AW'(24))
            rom_dout <= 8'hFF;
         else
            rom_dout <= 8'h10 + PW'(rom_raddr);
      end
   end

   function automatic logic [FW-1:0] kernel_img(bit f24);
      logic [FW-1:0] k;
      k = '0;
      for (int i = 0; i < KS; i++)
         k[i*PW +: PW] = (f24 && i == 24) ? 8'hFF : 8'(8'h10 + i);
      return k;
   endfunction

   task automatic check(string name, logic [FW-1:0] act, logic [FW-1:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s at cycle %0d: got %h expected %h",
                    name, cyc, act, exp);
   endtask

   // monitor
   always @(negedge clk) begin
      if (rom_r_en) begin
         if (req_q.size() == 0) begin
            check("unexpected_rom_req", 1'b1, 1'b0);
         end else begin
            check("req_cycle", FW'(cyc), FW'(req_q[0].cyc));
            check("req_addr", FW'(rom_raddr), FW'(req_q[0].addr));
            void'(req_q.pop_front());
         end
      end
      if (done) begin
         if (done_q.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
         end else begin
            check("done_cycle", FW'(cyc), FW'(done_q[0].cyc));
            check("done_flat", kernel_flat, done_q[0].flat);
            void'(done_q.pop_front());
         end
      end
      for (int i = snap_q.size() - 1; i >= 0; i--) begin
         if (snap_q[i].cyc == cyc) begin
            check("busy", FW'(busy), FW'(snap_q[i].busy));
            check("kernel_valid", FW'(kernel_valid), FW'(snap_q[i].kv));
            check("rom_r_en", FW'(rom_r_en), FW'(snap_q[i].ren));
            if (snap_q[i].chk_flat)
               check("kernel_flat", kernel_flat, snap_q[i].flat);
            snap_q.delete(i);
         end
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap(int c, logic b, logic kv, logic ren,
                       bit cf, logic [FW-1:0] f);
      snap_t s;
      s.cyc = c; s.busy = b; s.kv = kv; s.ren = ren;
      s.chk_flat = cf; s.flat = f;
      snap_q.push_back(s);
   endtask

   // expectations for a full load whose start is sampled in cycle c
   task automatic expect_load(int c, logic [FW-1:0] img);
      req_t  r;
      done_t d;
      for (int i = 0; i < KS; i++) begin
         r.cyc = c + 1 + i;
         r.addr = i;
         req_q.push_back(r);
      end
      d.cyc = c + KS + 2;
      d.flat = img;
      done_q.push_back(d);
      snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
      snap(c + KS + 1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      snap(c + KS + 2, 1'b1, 1'b1, 1'b0, 1'b1, img);
      snap(c + KS + 3, 1'b0, 1'b1, 1'b0, 1'b1, img);
   endtask

   initial begin
      int c;
      rst = 1'b1;
      start = 1'b0;
      tick(3);
      rst = 1'b0;
      snap(cyc, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      tick(2);

      // 1: single load
      c = cyc;
      expect_load(c, kernel_img(0));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(32);

      // 2: start held 30 cycles, second load only once back in IDLE
      c = cyc;
      expect_load(c, kernel_img(0));
      expect_load(c + KS + 3, kernel_img(0));
      snap(c + 10, 1'b1, 1'b0, 1'b1, 1'b0, '0);
      start = 1'b1;
      tick(30);
      start = 1'b0;
      tick(30);

      // 3: reload; contents stay identical while slots are rewritten
      c = cyc;
      expect_load(c, kernel_img(0));
      snap(c + 10, 1'b1, 1'b0, 1'b1, 1'b1, kernel_img(0));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(32);

      // 4: reset in cycle 10 of a load
      c = cyc;
      for (int i = 0; i < 10; i++) req_q.push_back('{c + 1 + i, i});
      snap(c + 1, 1'b1, 1'b0, 1'b1, 1'b0, '0);
      snap(c + 11, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      snap(c + 20, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick(35);

      // 5: corrupted word at address 24 lands only in slot 24
      force24 = 1'b1;
      c = cyc;
      expect_load(c, kernel_img(1));
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(32);
      force24 = 1'b0;

      // 6: start together with reset, reset wins
      c = cyc;
      snap(c + 1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      snap(c + 2, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      snap(c + 5, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      start = 1'b1;
      rst = 1'b1;
      tick();
      start = 1'b0;
      rst = 1'b0;
      tick(10);

      check("req_q_empty", FW'(req_q.size()), '0);
      check("done_q_empty", FW'(done_q.size()), '0);
      check("snap_q_empty", FW'(snap_q.size()), '0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
